// File: rtl/fetch_if.sv
// Fetch-stage bus: stall/redirect controls in, IF/ID register contents and status out.
// The master side (hazard unit / decode) drives controls; fetch_stage is the slave.
interface fetch_if;
    logic        enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] IR_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
    logic        valid_D;
    logic [31:0] PC_F;
    logic        fetch_err;

    modport master (
        output enable, redirect, redirect_pc,
        input  IR_D, PC_D, PC8_D, valid_D, PC_F, fetch_err
    );

    modport slave (
        input  enable, redirect, redirect_pc,
        output IR_D, PC_D, PC8_D, valid_D, PC_F, fetch_err
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register and combinational instruction ROM.
// Branch-delay-slot semantics: a redirect never squashes the instruction already fetched.
module fetch_stage #(
    parameter logic [31:0]            PC_RESET = 32'h0000_3000,
    parameter int unsigned            IM_DEPTH = 1024,
    // ROM image, word i at bits [32*i +: 32]; must be a power-of-two depth
    parameter logic [IM_DEPTH*32-1:0] IM_INIT  = '0
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.slave bus
);

    localparam int unsigned AddrW    = $clog2(IM_DEPTH);
    localparam logic [32:0] RomBytes = 33'(IM_DEPTH) << 2;

    logic [31:0] pc_f_q,  pc_f_d;
    logic [31:0] ir_d_q,  ir_d_d;
    logic [31:0] pc_d_q,  pc_d_d;
    logic [31:0] pc8_d_q, pc8_d_d;
    logic        valid_q, valid_d;
    logic        err_q,   err_d;

    logic [31:0]      offset;
    logic             in_range;
    logic [AddrW-1:0] rom_idx;
    logic [31:0]      ir_f;
    logic             misaligned;

    // PCs below PC_RESET wrap to a huge offset and fall out of range
    assign offset   = pc_f_q - PC_RESET;
    assign in_range = {1'b0, offset} < RomBytes;
    assign rom_idx  = offset[AddrW+1:2];
    assign ir_f     = in_range ? IM_INIT[{rom_idx, 5'b00000} +: 32] : 32'h0;

    assign misaligned = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

    always_comb begin
        pc_f_d  = pc_f_q;
        ir_d_d  = ir_d_q;
        pc_d_d  = pc_d_q;
        pc8_d_d = pc8_d_q;
        valid_d = valid_q;
        err_d   = err_q;
        // Stall wins over redirect; decode re-presents the redirect next cycle
        if (bus.enable) begin
            pc_f_d  = bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : pc_f_q + 32'd4;
            ir_d_d  = ir_f;
            pc_d_d  = pc_f_q;
            pc8_d_d = pc_f_q + 32'd8;
            valid_d = 1'b1;
            err_d   = err_q | misaligned | ~in_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_f_q  <= PC_RESET;
            ir_d_q  <= 32'h0;
            pc_d_q  <= 32'h0;
            pc8_d_q <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_f_q  <= pc_f_d;
            ir_d_q  <= ir_d_d;
            pc_d_q  <= pc_d_d;
            pc8_d_q <= pc8_d_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.PC_F      = pc_f_q;
    assign bus.IR_D      = ir_d_q;
    assign bus.PC_D      = pc_d_q;
    assign bus.PC8_D     = pc8_d_q;
    assign bus.valid_D   = valid_q;
    assign bus.fetch_err = err_q;

endmodule
